// File: rtl/win_track_pkg.sv
// Shared types and defaults for window_stream_tracker and its metadata delay pipe.
package win_track_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int DEF_IMG_W   = 640;
   localparam int DEF_IMG_H   = 480;
   localparam int DEF_WIN_LAT = 3;

   // Width-independent flags of the raw (stage 0) window metadata; the centre
   // coordinates are carried alongside because their widths are top parameters.
   typedef struct packed {
      logic win_valid;
      logic done;
   } meta_flags_t;

   localparam int META_FLAG_W = $bits(meta_flags_t);

endpackage

// File: rtl/win_meta_delay.sv
// WIDTH x DEPTH shift pipe with synchronous clear; DEPTH=0 is a plain wire.
module win_meta_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk_i ^ rst_i;
         assign dout_o = din_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe_q [DEPTH];

         // Shift metadata one stage per clock; reset flushes every stage.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= din_i;
               for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign dout_o = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/window_stream_tracker.sv
// Raster position tracker producing 3x3-window-aligned metadata (centre,
// window-valid, frame-done) delayed by WIN_LAT to match the window buffer.
// Optional feature macro: WIN_TRACK_BORDER_EN adds oborder and ozero_win.
module window_stream_tracker
   import win_track_pkg::*;
#(
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int XW      = 10,
   parameter int YW      = 9,
   parameter int WIN_LAT = DEF_WIN_LAT
) (
   input  logic          iclk,
   input  logic          irst,
   input  logic          ivalid,
   input  logic          isof,
   input  logic [8:0]    idata,
   output logic          owin_valid,
   output logic [XW-1:0] ocenter_x,
   output logic [YW-1:0] ocenter_y,
   output logic          oframe_done,
   output logic          oerr,
   output logic          obusy
`ifdef WIN_TRACK_BORDER_EN
   ,
   output logic          oborder,
   output logic          ozero_win
`endif
);

   localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
   localparam logic [XW-1:0] COL_BRD  = XW'(IMG_W - 2);
   localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
   localparam logic [YW-1:0] ROW_BRD  = YW'(IMG_H - 2);
   localparam logic [XW-1:0] X1       = XW'(1);
   localparam logic [XW-1:0] X2       = XW'(2);
   localparam logic [YW-1:0] Y1       = YW'(1);
   localparam logic [YW-1:0] Y2       = YW'(2);
`ifdef WIN_TRACK_BORDER_EN
   localparam int EXT_W = 2;
`else
   localparam int EXT_W = 0;
`endif
   localparam int META_W = META_FLAG_W + XW + YW + EXT_W;

   state_t        state_q;
   logic [XW-1:0] col_q;
   logic [YW-1:0] row_q;
   logic          err_q;

   logic          acc_p0;
   logic [XW-1:0] pc_p0;
   logic [YW-1:0] pr_p0;
   logic [XW-1:0] cx_p0;
   logic [YW-1:0] cy_p0;
   meta_flags_t   flags_p0;
   meta_flags_t   flags_out;
   logic [META_W-1:0] meta_p0;
   logic [META_W-1:0] meta_out;

   // Stage 0: position of the pixel accepted this cycle and its raw window metadata.
   always_comb begin
      acc_p0             = ivalid & (isof | (state_q == ACTIVE));
      pc_p0              = isof ? '0 : col_q;
      pr_p0              = isof ? '0 : row_q;
      flags_p0.win_valid = acc_p0 & (pc_p0 >= X2) & (pr_p0 >= Y2);
      flags_p0.done      = acc_p0 & (pc_p0 == COL_LAST) & (pr_p0 == ROW_LAST);
      cx_p0              = flags_p0.win_valid ? (pc_p0 - X1) : '0;
      cy_p0              = flags_p0.win_valid ? (pr_p0 - Y1) : '0;
   end

   // Frame FSM with column/row counters and sticky protocol error.
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ivalid && isof) begin
                  state_q <= ACTIVE;
                  col_q   <= X1;
                  row_q   <= '0;
               end else if (ivalid) begin
                  err_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (!ivalid) begin
                  // A gap desynchronises the free-running window buffer: drop the frame.
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                  col_q   <= '0;
                  row_q   <= '0;
               end else begin
                  if (isof) err_q <= 1'b1;
                  if (flags_p0.done) begin
                     state_q <= IDLE;
                     col_q   <= '0;
                     row_q   <= '0;
                  end else if (pc_p0 == COL_LAST) begin
                     col_q <= '0;
                     row_q <= pr_p0 + Y1;
                  end else begin
                     col_q <= pc_p0 + X1;
                     row_q <= pr_p0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef WIN_TRACK_BORDER_EN
   logic [(1<<XW)-1:0] zl1_q;
   logic [(1<<XW)-1:0] zl2_q;
   logic [1:0]         colz_q;
   logic               colz_p0;
   logic               border_p0;
   logic               zero_p0;

   // Stage 0: column-zero of the current column and the border/all-zero window flags.
   always_comb begin
      colz_p0   = (idata == '0) & zl1_q[pc_p0] & zl2_q[pc_p0];
      zero_p0   = flags_p0.win_valid & colz_p0 & colz_q[0] & colz_q[1];
      border_p0 = flags_p0.win_valid &
                  ((cx_p0 == X1) | (cx_p0 == COL_BRD) | (cy_p0 == Y1) | (cy_p0 == ROW_BRD));
   end

   // Zero history: per-column flags for the two previous lines, plus the last two column-zeros.
   always_ff @(posedge iclk) begin
      if (acc_p0) begin
         zl1_q[pc_p0] <= (idata == '0);
         zl2_q[pc_p0] <= zl1_q[pc_p0];
         colz_q       <= {colz_q[0], colz_p0};
      end
   end

   assign meta_p0 = {flags_p0, cx_p0, cy_p0, border_p0, zero_p0};
   assign {flags_out, ocenter_x, ocenter_y, oborder, ozero_win} = meta_out;
`else
   logic unused_idata;
   assign unused_idata = ^idata;
   assign meta_p0 = {flags_p0, cx_p0, cy_p0};
   assign {flags_out, ocenter_x, ocenter_y} = meta_out;
`endif

   win_meta_delay #(
      .WIDTH (META_W),
      .DEPTH (WIN_LAT)
   ) u_delay (
      .clk_i  (iclk),
      .rst_i  (irst),
      .din_i  (meta_p0),
      .dout_o (meta_out)
   );

   assign owin_valid  = flags_out.win_valid;
   assign oframe_done = flags_out.done;
   assign oerr        = err_q;
   assign obusy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_window_stream_tracker.sv
// Scoreboard bench for window_stream_tracker (IMG_W=8, IMG_H=6, WIN_LAT=3).
module tb_window_stream_tracker;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int LAT = 3;
   localparam int XW  = 3;
   localparam int YW  = 3;

   logic          iclk = 1'b0;
   logic          irst;
   logic          ivalid;
   logic          isof;
   logic [8:0]    idata;
   logic          owin_valid;
   logic [XW-1:0] ocenter_x;
   logic [YW-1:0] ocenter_y;
   logic          oframe_done;
   logic          oerr;
   logic          obusy;
`ifdef WIN_TRACK_BORDER_EN
   logic          oborder;
   logic          ozero_win;
`endif

   window_stream_tracker #(
      .IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .WIN_LAT(LAT)
   ) dut (
      .iclk(iclk), .irst(irst), .ivalid(ivalid), .isof(isof), .idata(idata),
      .owin_valid(owin_valid), .ocenter_x(ocenter_x), .ocenter_y(ocenter_y),
      .oframe_done(oframe_done), .oerr(oerr), .obusy(obusy)
`ifdef WIN_TRACK_BORDER_EN
      , .oborder(oborder), .ozero_win(ozero_win)
`endif
   );

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   typedef struct {
      int due;
      int cx;
      int cy;
      bit done;
      bit border;
      bit zero;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int vcnt = 0, dcnt = 0, bcnt = 0, zcnt = 0;

   // reference model: frame position as a linear pixel index
   bit m_active = 0;
   int m_idx = 0;
   bit m_err = 0;
   int frame_px [H][W];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d cycle %0d", name, act, req, cyc);
      end
   endtask

   // monitor: pops the expected window whenever the DUT presents one
   always @(negedge iclk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) begin
         checks++; errors++;
         $display("FAIL missed_window actual none required (%0d,%0d) cycle %0d", q[0].cx, q[0].cy, q[0].due);
         void'(q.pop_front());
      end
      if (owin_valid === 1'b1 || oframe_done === 1'b1) begin
         vcnt += (owin_valid === 1'b1) ? 1 : 0;
         dcnt += (oframe_done === 1'b1) ? 1 : 0;
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_window actual (%0d,%0d) required none cycle %0d", ocenter_x, ocenter_y, cyc);
         end else begin
            e = q.pop_front();
            chk("win_cycle", cyc, e.due);
            chk("win_valid", owin_valid, 1);
            chk("center_x", ocenter_x, e.cx);
            chk("center_y", ocenter_y, e.cy);
            chk("frame_done", oframe_done, e.done);
`ifdef WIN_TRACK_BORDER_EN
            chk("border", oborder, e.border);
            chk("zero_win", ozero_win, e.zero);
            bcnt += oborder ? 1 : 0;
            zcnt += ozero_win ? 1 : 0;
`endif
         end
      end else begin
         chk("idle_center", {ocenter_x, ocenter_y}, 0);
      end
   end

   // drive one cycle, update the model, then check the registered status
   task automatic drive(input bit v, input bit s, input logic [8:0] d);
      bit acc = 0;
      int pos = 0;
      int c, r;
      exp_t e;
      ivalid = v; isof = s; idata = d;
      if (v) begin
         if (s) begin
            if (m_active) m_err = 1;
            m_active = 1; pos = 0; m_idx = 1; acc = 1;
         end else if (m_active) begin
            pos = m_idx; m_idx++; acc = 1;
            if (m_idx == W*H) m_active = 0;
         end else begin
            m_err = 1;
         end
      end else if (m_active) begin
         m_err = 1; m_active = 0;
      end
      if (acc) begin
         c = pos % W; r = pos / W;
         frame_px[r][c] = int'(d);
         if (c >= 2 && r >= 2) begin
            e.due = cyc + LAT; e.cx = c - 1; e.cy = r - 1;
            e.done = (pos == W*H - 1);
            e.border = (e.cx == 1 || e.cx == W-2 || e.cy == 1 || e.cy == H-2);
            e.zero = 1;
            for (int yy = r-2; yy <= r; yy++)
               for (int xx = c-2; xx <= c; xx++)
                  if (frame_px[yy][xx] != 0) e.zero = 0;
            q.push_back(e);
         end
      end
      @(posedge iclk); #1;
      chk("oerr", oerr, m_err);
      chk("obusy", obusy, m_active);
   endtask

   task automatic do_reset();
      irst = 1; ivalid = 0; isof = 0; idata = '0;
      @(posedge iclk); #1;
      q.delete();
      m_active = 0; m_idx = 0; m_err = 0;
      chk("rst_win_valid", owin_valid, 0);
      chk("rst_done", oframe_done, 0);
      chk("rst_err", oerr, 0);
      chk("rst_busy", obusy, 0);
      chk("rst_cx", ocenter_x, 0);
      chk("rst_cy", ocenter_y, 0);
      irst = 0;
   endtask

   function automatic logic [8:0] rnd_px(input bit zero);
      if (zero || ($urandom % 4 == 0)) return '0;
      return 9'($urandom % 512);
   endfunction

   task automatic pixels(input int n, input bit zero);
      for (int k = 0; k < n; k++) drive(1, 0, rnd_px(zero));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, d0, k;
      bit zf;
      irst = 1; ivalid = 0; isof = 0; idata = '0;
      @(posedge iclk);
      do_reset();
      idle(2);

      // clean frame: 24 windows, one done
      v0 = vcnt; d0 = dcnt;
      drive(1, 1, rnd_px(0)); pixels(W*H-1, 0);
      idle(LAT + 2);
      chk("clean_win_count", vcnt - v0, 24);
      chk("clean_done_count", dcnt - d0, 1);
      chk("clean_err", oerr, 0);

      // gap at pixel (4,2), then a clean restart
      d0 = dcnt;
      drive(1, 1, rnd_px(0)); pixels(2*W + 4 - 1, 0);
      drive(0, 0, '0);
      idle(LAT + 2);
      chk("gap_no_done", dcnt - d0, 0);
      drive(1, 1, rnd_px(0)); pixels(W*H-1, 0);
      idle(LAT + 2);
      chk("gap_restart_done", dcnt - d0, 1);

      // early isof at pixel (5,1)
      do_reset();
      d0 = dcnt;
      drive(1, 1, rnd_px(0)); pixels(W + 5 - 1, 0);
      drive(1, 1, rnd_px(0)); pixels(W*H-1, 0);
      idle(LAT + 2);
      chk("early_sof_done", dcnt - d0, 1);
      chk("early_sof_err", oerr, 1);

      // reset at pixel (3,3): pipe flushed, nothing stale afterwards
      do_reset();
      v0 = vcnt;
      drive(1, 1, rnd_px(0)); pixels(3*W + 3 - 1, 0);
      do_reset();
      idle(LAT + 3);

      // randomized frames with occasional gaps, restarts and stray pixels
      for (int f = 0; f < 10; f++) begin
         idle($urandom % 4);
         if ($urandom % 5 == 0) drive(1, 0, rnd_px(0));
         zf = ($urandom % 3 == 0);
         drive(1, 1, rnd_px(zf));
         k = 1;
         while (k < W*H) begin
            int r = $urandom % 200;
            if (r < 2) begin drive(0, 0, '0); break; end
            else if (r < 4) begin drive(1, 1, rnd_px(zf)); k = 1; end
            else begin drive(1, 0, rnd_px(zf)); k++; end
         end
      end
      idle(LAT + 2);

`ifdef WIN_TRACK_BORDER_EN
      // all-zero frame: every window zero, 16 ring centres
      do_reset();
      v0 = bcnt; d0 = zcnt;
      drive(1, 1, '0); pixels(W*H-1, 1);
      idle(LAT + 2);
      chk("zero_frame_zero_count", zcnt - d0, 24);
      chk("zero_frame_border_count", bcnt - v0, 16);
`endif

      idle(2);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
